// File: rtl/conv_out_writer_if.sv
// Memory write port of the convolution output writer: one addressed beat
// per handshake, qualified by wr_valid and accepted when wr_ready is high.
interface conv_out_writer_if #(
  parameter int WR_WIDTH   = 48,
  parameter int ADDR_WIDTH = 20
);

  logic [WR_WIDTH-1:0]   wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_valid;
  logic                  wr_ready;

  // The writer drives the beat, the memory side answers with ready
  modport master (
    output wr_data,
    output wr_addr,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_addr,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/conv_out_writer.sv
// conv_out_writer: absorbs the per-pixel convolution result stream in a
// pixel FIFO, splits every pixel into BEATS memory words (lowest bits first)
// and writes them to sequential addresses starting at a per-frame base.
// Reports frame completion with a one-cycle pulse and dropped pixels with a
// sticky overflow flag.
module conv_out_writer #(
  parameter int CONV_OUT_NUM  = 18,
  parameter int DATA_WIDTH    = 8,
  parameter int WR_WIDTH      = 48,
  parameter int ADDR_WIDTH    = 20,
  parameter int FIFO_DEPTH    = 16,
  parameter int PIX_PER_FRAME = 320*240
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0] Conv_data_in,
  input  logic                               Conv_data_valid_in,
  conv_out_writer_if.master                  wr,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               overflow
);

  localparam int PIX_WIDTH = CONV_OUT_NUM * DATA_WIDTH;
  localparam int BEATS     = PIX_WIDTH / WR_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W    = PTR_W + 1;
  localparam int PCNT_W    = $clog2(PIX_PER_FRAME + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Pixel FIFO storage and bookkeeping
  logic [PIX_WIDTH-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
  logic [FCNT_W-1:0]    fifoCount_q, fifoCount_d;
  logic                 fifoFull, fifoEmpty;

  // Serializer: one pixel shifted down by a beat on every acceptance
  logic [PIX_WIDTH-1:0] serPixel_q;
  logic [BEAT_W-1:0]    beatIdx_q;
  logic                 serValid_q;

  // Address, frame progress and status
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PCNT_W-1:0]     pixCount_q, pixCount_d;
  logic                  frameDone_q;
  logic                  overflow_q;

  // Control strobes
  logic running;
  logic push;
  logic drop;
  logic load;
  logic accept;
  logic lastAccept;
  logic frameEnd;

  assign fifoFull   = (fifoCount_q == FCNT_W'(FIFO_DEPTH));
  assign fifoEmpty  = (fifoCount_q == '0);
  assign running    = (state_q == RUN) && !start;
  assign accept     = serValid_q && wr.wr_ready;
  assign lastAccept = accept && (beatIdx_q == BEAT_W'(BEATS - 1));
  assign frameEnd   = running && lastAccept &&
                      (pixCount_q == PCNT_W'(PIX_PER_FRAME - 1));
  // A full FIFO refuses the pixel even if a pop happens in the same cycle
  assign push       = running && Conv_data_valid_in && !fifoFull;
  assign drop       = running && Conv_data_valid_in && fifoFull;
  // Refill the serializer when empty or as its last beat leaves, but never
  // pull a pixel beyond the end of the frame
  assign load       = running && !fifoEmpty &&
                      (!serValid_q || (lastAccept && !frameEnd));

  // Next-state logic: start always (re)enters RUN, the final pixel ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (start)         state_d = RUN;
        else if (frameEnd) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next values of the FIFO occupancy, write address and pixel count
  always_comb begin
    fifoCount_d = fifoCount_q;
    addr_d      = addr_q;
    pixCount_d  = pixCount_q;
    if (start) begin
      fifoCount_d = '0;
      addr_d      = base_addr;
      pixCount_d  = '0;
    end else begin
      case ({push, load})
        2'b10:   fifoCount_d = fifoCount_q + FCNT_W'(1);
        2'b01:   fifoCount_d = fifoCount_q - FCNT_W'(1);
        default: fifoCount_d = fifoCount_q;
      endcase
      if (accept)     addr_d     = addr_q + ADDR_WIDTH'(1);
      if (lastAccept) pixCount_d = pixCount_q + PCNT_W'(1);
    end
  end

  // Pixel storage is a plain memory without reset
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= Conv_data_in;
  end

  // FIFO pointers and occupancy, flushed by start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      fifoCount_q <= fifoCount_d;
      if (start) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
        if (load) rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
    end
  end

  // Serializer: load a whole pixel, then shift one beat out per acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      serPixel_q <= '0;
      beatIdx_q  <= '0;
      serValid_q <= 1'b0;
    end else if (start) begin
      serPixel_q <= '0;
      beatIdx_q  <= '0;
      serValid_q <= 1'b0;
    end else if (load) begin
      serPixel_q <= fifoMem_q[rdPtr_q];
      beatIdx_q  <= '0;
      serValid_q <= 1'b1;
    end else if (accept) begin
      serPixel_q <= serPixel_q >> WR_WIDTH;
      if (beatIdx_q == BEAT_W'(BEATS - 1)) begin
        beatIdx_q  <= '0;
        serValid_q <= 1'b0;
      end else begin
        beatIdx_q <= beatIdx_q + BEAT_W'(1);
      end
    end
  end

  // Beat address and frame pixel count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      pixCount_q <= '0;
    end else begin
      addr_q     <= addr_d;
      pixCount_q <= pixCount_d;
    end
  end

  // Frame-complete pulse and sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frameDone_q <= frameEnd;
      if (start)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
    end
  end

  assign wr.wr_valid = serValid_q;
  assign wr.wr_data  = serPixel_q[WR_WIDTH-1:0];
  assign wr.wr_addr  = addr_q;
  assign busy        = (state_q == RUN);
  assign frame_done  = frameDone_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer. Stimulus pushes the beats it expects
// into a queue; a monitor on the falling edge pops and compares every
// accepted beat and watches stall stability and the frame-done pulse.
module tb_conv_out_writer;

  localparam int NCH   = 18;
  localparam int DW    = 8;
  localparam int PW    = NCH * DW;
  localparam int WW    = 48;
  localparam int AW    = 20;
  localparam int FRAME = 20;

  typedef struct {
    logic [WW-1:0] data;
    logic [AW-1:0] addr;
  } beat_t;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [PW-1:0] Conv_data_in;
  logic          Conv_data_valid_in;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  conv_out_writer_if #(.WR_WIDTH(WW), .ADDR_WIDTH(AW)) wrIf ();

  conv_out_writer #(
    .CONV_OUT_NUM (NCH),
    .DATA_WIDTH   (DW),
    .WR_WIDTH     (WW),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (16),
    .PIX_PER_FRAME(FRAME)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start             (start),
    .base_addr         (base_addr),
    .Conv_data_in      (Conv_data_in),
    .Conv_data_valid_in(Conv_data_valid_in),
    .wr                (wrIf),
    .busy              (busy),
    .frame_done        (frame_done),
    .overflow          (overflow)
  );

  int            checks = 0;
  int            errors = 0;
  beat_t         expQ[$];
  logic [AW-1:0] expAddr = '0;
  int            cycle = 0;
  int            lastAcceptCycle = 0;
  logic [AW-1:0] lastAcceptAddr = '0;
  int            frameDoneCount = 0;
  bit            stallPending = 0;
  logic [WW-1:0] stallData;
  logic [AW-1:0] stallAddr;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] makePix(input logic [7:0] seed);
    logic [PW-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*DW +: DW] = seed + 8'(c);
    return p;
  endfunction

  task automatic pushPix(input logic [PW-1:0] pix);
    beat_t b;
    for (int k = 0; k < PW / WW; k++) begin
      b.data  = pix[k*WW +: WW];
      b.addr  = expAddr;
      expQ.push_back(b);
      expAddr = expAddr + AW'(1);
    end
  endtask

  // One valid pixel cycle; caller is positioned just after a rising edge
  task automatic applyStimulus(input logic [PW-1:0] pix, input bit expectWrite);
    Conv_data_in       = pix;
    Conv_data_valid_in = 1'b1;
    if (expectWrite) pushPix(pix);
    @(posedge clk); #1;
    Conv_data_valid_in = 1'b0;
  endtask

  task automatic doStart(input logic [AW-1:0] base, input bit withPix,
                         input logic [PW-1:0] pix);
    start     = 1'b1;
    base_addr = base;
    if (withPix) begin
      Conv_data_in       = pix;
      Conv_data_valid_in = 1'b1;
    end
    @(posedge clk); #1;
    start              = 1'b0;
    Conv_data_valid_in = 1'b0;
    expAddr            = base;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("overflow_after_start", 64'(overflow), 64'd0);
    checkOutput("wr_valid_after_start", 64'(wrIf.wr_valid), 64'd0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Monitor: compare accepted beats, stall stability and frame_done timing
  always @(negedge clk) begin
    if (rstn) begin
      cycle++;
      if (stallPending) begin
        checkOutput("stall_valid_held", 64'(wrIf.wr_valid), 64'd1);
        checkOutput("stall_data_held", 64'(wrIf.wr_data), 64'(stallData));
        checkOutput("stall_addr_held", 64'(wrIf.wr_addr), 64'(stallAddr));
        stallPending = 0;
      end
      if (wrIf.wr_valid && !wrIf.wr_ready) begin
        stallPending = 1;
        stallData    = wrIf.wr_data;
        stallAddr    = wrIf.wr_addr;
      end
      if (start) stallPending = 0;
      if (wrIf.wr_valid && wrIf.wr_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat_addr", 64'(wrIf.wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("beat_data", 64'(wrIf.wr_data), 64'(e.data));
          checkOutput("beat_addr", 64'(wrIf.wr_addr), 64'(e.addr));
        end
        lastAcceptCycle = cycle;
        lastAcceptAddr  = wrIf.wr_addr;
      end
      if (frame_done) begin
        frameDoneCount++;
        checkOutput("frame_done_delay", 64'(cycle - lastAcceptCycle), 64'd1);
        checkOutput("busy_at_frame_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    beat_t b;
    rstn               = 1'b0;
    start              = 1'b0;
    base_addr          = '0;
    Conv_data_in       = '0;
    Conv_data_valid_in = 1'b0;
    wrIf.wr_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wr_valid", 64'(wrIf.wr_valid), 64'd0);
    checkOutput("reset_wr_data", 64'(wrIf.wr_data), 64'd0);
    checkOutput("reset_wr_addr", 64'(wrIf.wr_addr), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_frame_done", 64'(frame_done), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single pixel, hand-computed beats and two-cycle latency
    $display("[TB] single pixel at 0x100");
    wrIf.wr_ready = 1'b1;
    doStart(20'h00100, 0, '0);
    b.data = 48'h050403020100; b.addr = 20'h00100; expQ.push_back(b);
    b.data = 48'h0B0A09080706; b.addr = 20'h00101; expQ.push_back(b);
    b.data = 48'h11100F0E0D0C; b.addr = 20'h00102; expQ.push_back(b);
    applyStimulus(makePix(8'h00), 0);
    checkOutput("latency_not_yet_valid", 64'(wrIf.wr_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency_valid", 64'(wrIf.wr_valid), 64'd1);
    checkOutput("latency_beat0_data", 64'(wrIf.wr_data), 64'h050403020100);
    checkOutput("latency_beat0_addr", 64'(wrIf.wr_addr), 64'h00100);
    waitDrain(50);

    // wr_ready 1-0-0-1 pattern while four pixels flow through
    $display("[TB] ready toggling, 4 pixels");
    doStart(20'h00010, 0, '0);
    fork
      begin
        for (int c = 0; c < 48; c++) begin
          wrIf.wr_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk); #1;
        end
        wrIf.wr_ready = 1'b1;
      end
      begin
        for (int p = 0; p < 4; p++) applyStimulus(makePix(8'(8'h20 + 8'(p * 16))), 1);
      end
    join
    waitDrain(100);
    checkOutput("toggle_no_overflow", 64'(overflow), 64'd0);

    // Overflow: 16 in the FIFO plus one in the serializer, the 18th dropped
    $display("[TB] overflow with wr_ready low");
    wrIf.wr_ready = 1'b0;
    doStart(20'h00300, 0, '0);
    for (int p = 0; p < 17; p++) applyStimulus(makePix(8'(8'h40 + 8'(p))), 1);
    checkOutput("overflow_before_drop", 64'(overflow), 64'd0);
    applyStimulus(makePix(8'hE0), 0);
    checkOutput("overflow_after_drop", 64'(overflow), 64'd1);
    wrIf.wr_ready = 1'b1;
    waitDrain(200);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);

    // Restart mid-frame with two buffered pixels
    $display("[TB] restart with buffered pixels");
    wrIf.wr_ready = 1'b0;
    applyStimulus(makePix(8'hA0), 0);
    applyStimulus(makePix(8'hB0), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("buffered_stalled_valid", 64'(wrIf.wr_valid), 64'd1);
    doStart(20'h00200, 0, '0);
    wrIf.wr_ready = 1'b1;
    applyStimulus(makePix(8'h60), 1);
    waitDrain(50);

    // Frame completion after FRAME pixels; two more are never written
    $display("[TB] frame completion");
    doStart(20'h00400, 0, '0);
    frameDoneCount = 0;
    for (int p = 0; p < FRAME + 2; p++) begin
      applyStimulus(makePix(8'(8'h70 + 8'(p))), p < FRAME);
      repeat (2) @(posedge clk);
      #1;
    end
    waitDrain(100);
    checkOutput("frame_done_pulses", 64'(frameDoneCount), 64'd1);
    checkOutput("frame_busy_low", 64'(busy), 64'd0);
    checkOutput("frame_last_addr", 64'(lastAcceptAddr), 64'h0043B);

    // Address wrap; a pixel coincident with start is discarded
    $display("[TB] address wrap");
    doStart(20'hFFFFE, 1, makePix(8'hC0));
    applyStimulus(makePix(8'h90), 1);
    waitDrain(50);
    checkOutput("wrap_last_addr", 64'(lastAcceptAddr), 64'h00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
